// File: rtl/fpu_pkg.sv
// Shared constants for the PCPI FPU sequencer: opcode/funct7 decode values,
// unit indices and the sequencer state encoding.
package fpu_pkg;

  localparam logic [6:0] OP_FP       = 7'b1010011;
  localparam logic [6:0] FADD_FUNCT7 = 7'b0000000;
  localparam logic [6:0] FSUB_FUNCT7 = 7'b0000100;
  localparam logic [6:0] FMUL_FUNCT7 = 7'b0001000;

  localparam int UNIT_ADD = 0;
  localparam int UNIT_MUL = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic match;
    logic unitSel;
    logic negB;
  } dec_t;

endpackage

// File: rtl/fpu_pcpi_sequencer_if.sv
// PCPI-side and unit-side signals of the FPU sequencer; the sequencer is the
// slave, the core plus the arithmetic units together form the master.
interface fpu_pcpi_sequencer_if;

  logic        pcpiValidIn;
  logic [31:0] pcpiInstIn;
  logic [31:0] pcpiRs1In;
  logic [31:0] pcpiRs2In;
  logic        pcpiWrOut;
  logic [31:0] pcpiRdOut;
  logic        pcpiWaitOut;
  logic        pcpiReadyOut;
  logic [1:0]  unitStartOut;
  logic [31:0] unitAOut;
  logic [31:0] unitBOut;
  logic [1:0]  unitValidIn;
  logic [63:0] unitDataIn;
  logic        timeoutOut;

  modport slave (
    input  pcpiValidIn, pcpiInstIn, pcpiRs1In, pcpiRs2In, unitValidIn, unitDataIn,
    output pcpiWrOut, pcpiRdOut, pcpiWaitOut, pcpiReadyOut,
    output unitStartOut, unitAOut, unitBOut, timeoutOut
  );

  modport master (
    output pcpiValidIn, pcpiInstIn, pcpiRs1In, pcpiRs2In, unitValidIn, unitDataIn,
    input  pcpiWrOut, pcpiRdOut, pcpiWaitOut, pcpiReadyOut,
    input  unitStartOut, unitAOut, unitBOut, timeoutOut
  );

endinterface

// File: rtl/fpu_pcpi_decode.sv
// Combinational decode of fadd.s / fsub.s / fmul.s into {match, unitSel, negB}.
// Zero latency; rounding mode and register fields play no part in the decision.
module fpu_pcpi_decode
  import fpu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [6:0] i_funct7,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_opcode == OP_FP) begin
      case (i_funct7)
        FADD_FUNCT7: o_dec = '{match: 1'b1, unitSel: 1'(UNIT_ADD), negB: 1'b0};
        FSUB_FUNCT7: o_dec = '{match: 1'b1, unitSel: 1'(UNIT_ADD), negB: 1'b1};
        FMUL_FUNCT7: o_dec = '{match: 1'b1, unitSel: 1'(UNIT_MUL), negB: 1'b0};
        default:     o_dec = '0;
      endcase
    end
  end

endmodule

// File: rtl/fpu_pcpi_sequencer.sv
// PCPI front end that issues one FP add/sub/mul at a time to shared units.
// Ready arrives 2+L cycles after acceptance for a unit latency L; stalls bounded by TIMEOUT_CYCLES.
module fpu_pcpi_sequencer
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clkIn,
  input  logic                 rstLowIn,
  fpu_pcpi_sequencer_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  dec_t        w_dec;
  logic        r_sel;
  logic        r_wait;
  logic        r_timeout;
  logic [7:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rd;
  logic        w_accept;
  logic        w_abort;
  logic        w_result;
  logic        w_expire;
  logic [31:0] w_dataSel;
  logic        w_unused;

  fpu_pcpi_decode u_decode (
    .i_opcode (bus.pcpiInstIn[6:0]),
    .i_funct7 (bus.pcpiInstIn[31:25]),
    .o_dec    (w_dec)
  );

  assign w_unused  = ^bus.pcpiInstIn[24:7];
  assign w_accept  = (r_state == IDLE) && bus.pcpiValidIn && w_dec.match;
  assign w_abort   = !bus.pcpiValidIn;
  assign w_result  = bus.unitValidIn[r_sel];
  assign w_expire  = (r_cnt == CNT_LAST);
  assign w_dataSel = (r_sel == 1'(UNIT_MUL)) ? bus.unitDataIn[63:32] : bus.unitDataIn[31:0];

  // Wait is a true flop so the core never sees a decode glitch on it.
  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_state <= IDLE;
      r_wait  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_next == ISSUE) || (w_next == WAIT) || (w_next == RESP);
    end
  end

  // Priority in WAIT: a dropped valid beats a result, a result beats expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = w_abort ? IDLE : WAIT;
      WAIT: begin
        if (w_abort)       w_next = IDLE;
        else if (w_result) w_next = RESP;
        else if (w_expire) w_next = IDLE;
      end
      RESP:    w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.unitStartOut = 2'b00;
    bus.pcpiReadyOut = 1'b0;
    bus.pcpiWrOut    = 1'b0;
    case (r_state)
      ISSUE: bus.unitStartOut[r_sel] = 1'b1;
      RESP: begin
        bus.pcpiReadyOut = 1'b1;
        bus.pcpiWrOut    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= 1'b0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= bus.pcpiRs1In;
        r_b       <= w_dec.negB ? {~bus.pcpiRs2In[31], bus.pcpiRs2In[30:0]} : bus.pcpiRs2In;
        r_sel     <= w_dec.unitSel;
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end
      if (r_state == WAIT) begin
        r_cnt <= r_cnt + 8'd1;
        if (!w_abort && w_result)      r_rd      <= w_dataSel;
        else if (!w_abort && w_expire) r_timeout <= 1'b1;
      end
    end
  end

  assign bus.pcpiWaitOut = r_wait;
  assign bus.pcpiRdOut   = r_rd;
  assign bus.unitAOut    = r_a;
  assign bus.unitBOut    = r_b;
  assign bus.timeoutOut  = r_timeout;

endmodule
